dlatch_bist_driver: RTL and testbench
=====================================

Name: dlatch_bist_driver

Overview:
- Hardware stimulus and checker that drives the D/enable inputs of a gated D latch and samples its Q/Q̄ outputs.
- Acts as the on-board, self-checking counterpart of the latch under test; results appear on LED-style outputs.
- Steps through a fixed 11-vector sequence, covering transparency, hold, return to transparency, repeated hold and final transparency.
- Counts executed and failing vectors.

Parameters:
- SETTLE_CYCLES, 4: clock cycles between applying a vector and sampling the latch (≥1).
- CNT_W, 4: width of the count outputs (≥4; must hold 11).

Ports:
- input_clock1_clk_1  in  1  system clock, rising-edge.
- input_push_button2_rst_n_2  in  1  reset, asynchronous, active-low.
- input_push_button3_start_3  in  1  start request; a rising edge is detected internally.
- input_latch_q_4  in  1  latch Q.
- input_latch_qn_5  in  1  latch Q̄.
- output_led1_d_6  out  1  drives latch D.
- output_led2_en_7  out  1  drives latch enable/clock.
- output_led3_busy_8  out  1  sequence running.
- output_led4_done_9  out  1  sequence complete.
- output_led5_pass_10  out  1  done and zero failures.
- output_test_count_11  out  CNT_W  vectors checked.
- output_fail_count_12  out  CNT_W  vectors failed.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - State goes to IDLE.
  - All outputs are 0.
  - Vector index, start-edge register, expected-Q register and known flag are all cleared.
- Vector table, idx 0..10, as (D,EN):
  - (0,1) (1,1) (0,1) (0,0) (1,0) (1,1) (0,1) (0,0) (1,0) (0,0) (1,1).
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE and DONE:
  - EN driven 0; D holds its last value.
  - A start rising edge (start=1 and registered start=0) goes to APPLY.
  - On that transition: counters cleared, idx=0, known=0, busy=1, done=0, pass=0.
- APPLY, 1 cycle:
  - Register D and EN from table[idx].
  - If EN=1: q_exp<=D and known<=1.
  - Then go to SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles (down-counter), then CHECK.
- CHECK, 1 cycle:
  - A vector passes when q≠qn AND (known=0 OR q==q_exp).
  - test_count increments; fail_count increments on a failure.
  - If idx==10, go to DONE; otherwise idx++ and go to APPLY.
- DONE:
  - busy=0, done=1.
  - pass=1 if and only if fail_count==0.
  - Outputs hold until the next start edge or reset.
- Latency: done rises 1+11×(SETTLE_CYCLES+2) cycles after the edge that detects start (67 at the default).
- Start edges while busy are ignored. A start held high does not retrigger.
- Counts never wrap: at most 11 with CNT_W≥4.
- A reset mid-run aborts immediately. The next start restarts from idx 0.
- q and qn are used only in CHECK, sampled synchronously on the clock edge.

Optional Feature:
- Macro: DLATCH_BIST_FIRST_FAIL_EN.
- When defined:
  - Adds port output_first_fail_13, out, CNT_W.
  - It holds idx+1 of the first failing vector in the current run, or 0 if no vector has failed.
  - It is cleared on reset and at the start of each run.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-clock → all outputs 0 with no clock edge needed; deassert, stay in IDLE, busy=0.
- Ideal latch model, SETTLE_CYCLES=4, pulse start → busy=1 the next cycle; done=1 at +67 cycles; test_count=11, fail_count=0, pass=1.
- Q stuck at 0, qn=1 → vectors 1, 5 and 10 fail; fail_count=3, pass=0, first_fail=2 (with the macro).
- Q tied to Q̄ (both 0) → every vector fails; fail_count=11, test_count=11, pass=0.
- Latch that ignores enable (q=d, qn=~d) → vectors 4 and 8 fail; fail_count=2, first_fail=5.
- Mid-run and retrigger, in order:
  - Start, then rst_n=0 at cycle 20 → outputs immediately 0.
  - Restart with the ideal model → full run, pass=1.
  - Hold start high throughout busy → exactly one run; test_count=11.

Source files
------------

// File: rtl/dlatch_bist_driver.sv
// Built-in self-test driver for a gated D latch: steps an 11-vector D/EN sequence, checks Q/Q-bar, reports on LEDs.
// Optional: define DLATCH_BIST_FIRST_FAIL_EN to add output_first_fail_13 (1-based index of first failing vector).
module dlatch_bist_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button2_rst_n_2,
    input  logic             input_push_button3_start_3,
    input  logic             input_latch_q_4,
    input  logic             input_latch_qn_5,
    output logic             output_led1_d_6,
    output logic             output_led2_en_7,
    output logic             output_led3_busy_8,
    output logic             output_led4_done_9,
    output logic             output_led5_pass_10,
    output logic [CNT_W-1:0] output_test_count_11,
    output logic [CNT_W-1:0] output_fail_count_12
`ifdef DLATCH_BIST_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0] output_first_fail_13
`endif
);

    localparam int SCW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    logic clk;
    logic rst_n;
    assign clk   = input_clock1_clk_1;
    assign rst_n = input_push_button2_rst_n_2;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [SCW-1:0]   cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             qexp_q, qexp_d;
    logic             known_q, known_d;
    logic             d_q, d_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] test_q, test_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] first_q, first_d;

    logic start_edge;
    logic vec_ok;
    logic [1:0] vec;

    // Vector table as {D, EN}
    function automatic logic [1:0] vec_de(input logic [3:0] i);
        case (i)
            4'd0:    vec_de = 2'b01;
            4'd1:    vec_de = 2'b11;
            4'd2:    vec_de = 2'b01;
            4'd3:    vec_de = 2'b00;
            4'd4:    vec_de = 2'b10;
            4'd5:    vec_de = 2'b11;
            4'd6:    vec_de = 2'b01;
            4'd7:    vec_de = 2'b00;
            4'd8:    vec_de = 2'b10;
            4'd9:    vec_de = 2'b00;
            4'd10:   vec_de = 2'b11;
            default: vec_de = 2'b00;
        endcase
    endfunction

    assign start_edge = input_push_button3_start_3 & ~start_q;
    assign vec        = vec_de(idx_q);
    assign vec_ok     = (input_latch_q_4 != input_latch_qn_5) &&
                        (!known_q || (input_latch_q_4 == qexp_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start_d = input_push_button3_start_3;
        qexp_d  = qexp_q;
        known_d = known_q;
        d_d     = d_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        test_d  = test_q;
        fail_d  = fail_q;
        first_d = first_q;

        unique case (state_q)
            IDLE, DONE: begin
                en_d = 1'b0;
                // Status flags settle one cycle after entering DONE so pass sees the final count
                if (state_q == DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (fail_q == '0);
                end
                if (start_edge) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    known_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    test_d  = '0;
                    fail_d  = '0;
                    first_d = '0;
                end
            end
            APPLY: begin
                d_d  = vec[1];
                en_d = vec[0];
                if (vec[0]) begin
                    qexp_d  = vec[1];
                    known_d = 1'b1;
                end
                cnt_d   = SCW'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            CHECK: begin
                test_d = test_q + CNT_W'(1);
                if (!vec_ok) begin
                    fail_d = fail_q + CNT_W'(1);
                    if (first_q == '0) begin
                        first_d = CNT_W'(idx_q) + CNT_W'(1);
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            qexp_q  <= 1'b0;
            known_q <= 1'b0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            test_q  <= '0;
            fail_q  <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            qexp_q  <= qexp_d;
            known_q <= known_d;
            d_q     <= d_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            test_q  <= test_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    assign output_led1_d_6      = d_q;
    assign output_led2_en_7     = en_q;
    assign output_led3_busy_8   = busy_q;
    assign output_led4_done_9   = done_q;
    assign output_led5_pass_10  = pass_q;
    assign output_test_count_11 = test_q;
    assign output_fail_count_12 = fail_q;

`ifdef DLATCH_BIST_FIRST_FAIL_EN
    assign output_first_fail_13 = first_q;
`else
    logic unused_first;
    assign unused_first = ^first_q;
`endif

endmodule

// File: tb/tb_dlatch_bist_driver.sv
// Bench for dlatch_bist_driver: behavioural latch with fault modes, scoreboard of predicted run results.
module tb_dlatch_bist_driver;

    localparam int S   = 4;
    localparam int CW  = 4;
    localparam int LAT = 1 + 11 * (S + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, lq, lqn;
    logic          led_d, led_en, busy, done, pass;
    logic [CW-1:0] tcnt, fcnt;
`ifdef DLATCH_BIST_FIRST_FAIL_EN
    logic [CW-1:0] ffail;
`endif

    dlatch_bist_driver #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .input_clock1_clk_1        (clk),
        .input_push_button2_rst_n_2(rst_n),
        .input_push_button3_start_3(start),
        .input_latch_q_4           (lq),
        .input_latch_qn_5          (lqn),
        .output_led1_d_6           (led_d),
        .output_led2_en_7          (led_en),
        .output_led3_busy_8        (busy),
        .output_led4_done_9        (done),
        .output_led5_pass_10       (pass),
        .output_test_count_11      (tcnt),
        .output_fail_count_12      (fcnt)
`ifdef DLATCH_BIST_FIRST_FAIL_EN
        ,
        .output_first_fail_13      (ffail)
`endif
    );

    // Latch modes: 0 ideal, 1 Q stuck 0, 2 Q tied to Qn (both 0), 3 ignores enable,
    // 4 Q stuck 1, 5 both 1, 6 inverted outputs
    int   mode = 0;
    logic lat  = 1'b0;
    always @(negedge clk) if (led_en) lat <= led_d;

    always_comb begin
        lq  = lat;
        lqn = ~lat;
        case (mode)
            1: begin lq = 1'b0;   lqn = 1'b1;   end
            2: begin lq = 1'b0;   lqn = 1'b0;   end
            3: begin lq = led_d;  lqn = ~led_d; end
            4: begin lq = 1'b1;   lqn = 1'b0;   end
            5: begin lq = 1'b1;   lqn = 1'b1;   end
            6: begin lq = ~lat;   lqn = lat;    end
            default: ;
        endcase
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int tc;
        int fc;
        int ps;
        int ff;
    } exp_t;
    exp_t sbq[$];

    int tD[11]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1};
    int tEN[11] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1};

    // Vector-level model: an ideal latch state gives the expected Q; the faulty device gives the observed Q/Qn
    function automatic exp_t predict(input int m);
        exp_t e;
        int ideal = 0;
        int q, qn;
        e.tc = 11; e.fc = 0; e.ff = 0;
        for (int i = 0; i < 11; i++) begin
            if (tEN[i] == 1) ideal = tD[i];
            case (m)
                1: begin q = 0;         qn = 1;         end
                2: begin q = 0;         qn = 0;         end
                3: begin q = tD[i];     qn = 1 - tD[i]; end
                4: begin q = 1;         qn = 0;         end
                5: begin q = 1;         qn = 1;         end
                6: begin q = 1 - ideal; qn = ideal;     end
                default: begin q = ideal; qn = 1 - ideal; end
            endcase
            if (q == qn || q != ideal) begin
                e.fc++;
                if (e.ff == 0) e.ff = i + 1;
            end
        end
        e.ps = (e.fc == 0) ? 1 : 0;
        return e;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each rising done is one completed run to compare against the scoreboard
    logic prev_busy = 1'b0, prev_done = 1'b0;
    int   t_start   = 0;
    always @(negedge clk) begin
        if (busy && !prev_busy) t_start <= cyc;
        if (done && !prev_done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("test_count", int'(tcnt), e.tc);
                chk("fail_count", int'(fcnt), e.fc);
                chk("pass", int'(pass), e.ps);
                chk("done_latency", cyc - t_start, LAT);
`ifdef DLATCH_BIST_FIRST_FAIL_EN
                chk("first_fail", int'(ffail), e.ff);
`endif
            end
        end
        prev_busy <= busy;
        prev_done <= done;
    end

    task automatic do_run(input int m, input bit hold, input bit poke);
        int n;
        mode = m;
        sbq.push_back(predict(m));
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 chk("busy_next_cycle", int'(busy), 1);
        if (!hold) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk) start = 1'b0;
        end
        if (poke) begin
            repeat ($urandom_range(5, 40)) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
        if (hold) begin
            repeat (10) @(negedge clk);
            chk("hold_no_retrigger_busy", int'(busy), 0);
            chk("hold_test_count", int'(tcnt), 11);
            start = 1'b0;
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d"}, int'(led_d), 0);
        chk({tag, "_en"}, int'(led_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_tcnt"}, int'(tcnt), 0);
        chk({tag, "_fcnt"}, int'(fcnt), 0);
`ifdef DLATCH_BIST_FIRST_FAIL_EN
        chk({tag, "_ffail"}, int'(ffail), 0);
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        do_run(0, 1'b0, 1'b0);
        do_run(1, 1'b0, 1'b0);
        do_run(2, 1'b0, 1'b0);
        do_run(3, 1'b0, 1'b0);

        // Abort mid-run: asynchronous reset clears everything without a clock edge
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (18) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run(0, 1'b0, 1'b0);
        do_run(0, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_run(int'($urandom_range(0, 6)), 1'b0, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
